// File: rtl/collatz_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// collatz_sweep_ctrl
//
// Sweeps the iterative Collatz step datapath over the seeds
// base .. base+count-1. For each seed the controller does three things:
//   1. It loads the datapath.
//   2. It lets the datapath step until it reports not-busy, or until the step
//      budget (MAX_STEPS RUN cycles) runs out.
//   3. It collects the datapath results.
// Across the sweep it keeps the seed with the strictly longest orbit and the
// largest path record. Seeds that time out do not take part in either result.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   cmd_start         start a sweep (accepted only while idle)
//   cmd_base/count    first seed / number of seeds, sampled with cmd_start
//   cmd_abort         end the sweep early (LOAD/RUN/COLLECT only)
//   dp_load/dp_seed   one-cycle load strobe and the seed to load
//   dp_run            datapath steps this cycle
//   dp_busy           datapath still iterating (valid from cycle after load)
//   dp_orbit_len      datapath orbit length, sampled in COLLECT
//   dp_path_record    datapath maximum value, sampled in COLLECT
//   busy, done        not idle / one-cycle end-of-sweep pulse
//   aborted           sweep ended by cmd_abort; held until next start
//   timeout_seen      sticky: some seed used the whole step budget
//   wrapped           sticky: the seed counter wrapped past all-ones
//   seeds_done        seeds collected so far
//   best_seed/len     seed with the longest orbit and that orbit length
//   best_record       largest path record among non-timed-out seeds
//
// Datapath handshake:
//   dp_load is high for the single LOAD cycle, with dp_seed stable.
//   From the next cycle on, dp_busy is valid. In RUN, dp_run mirrors dp_busy,
//   so the datapath advances exactly one step in each cycle it reports busy.
//   The first RUN cycle that sees dp_busy low ends the seed. The results are
//   then taken in the following COLLECT cycle.
// -----------------------------------------------------------------------------
module collatz_sweep_ctrl #(
  parameter int BITS      = 32,
  parameter int CNT_BITS  = 16,
  parameter int MAX_STEPS = 4096
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_start,
  input  logic [BITS-1:0]     cmd_base,
  input  logic [CNT_BITS-1:0] cmd_count,
  input  logic                cmd_abort,
  output logic                dp_load,
  output logic [BITS-1:0]     dp_seed,
  output logic                dp_run,
  input  logic                dp_busy,
  input  logic [BITS-1:0]     dp_orbit_len,
  input  logic [BITS-1:0]     dp_path_record,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic                timeout_seen,
  output logic                wrapped,
  output logic [CNT_BITS-1:0] seeds_done,
  output logic [BITS-1:0]     best_seed,
  output logic [BITS-1:0]     best_len,
  output logic [BITS-1:0]     best_record
);

  // The step counter only has to reach MAX_STEPS-1; the seed leaves RUN there.
  localparam int                 STEP_W    = $clog2(MAX_STEPS);
  localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(MAX_STEPS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_RUN     = 3'd2,
    S_COLLECT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [BITS-1:0]     cur_seed_q, cur_seed_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
  logic                seed_to_q, seed_to_d;
  logic                aborted_q, aborted_d;
  logic                timeout_seen_q, timeout_seen_d;
  logic                wrapped_q, wrapped_d;
  logic [CNT_BITS-1:0] seeds_done_q, seeds_done_d;
  logic [BITS-1:0]     best_seed_q, best_seed_d;
  logic [BITS-1:0]     best_len_q, best_len_d;
  logic [BITS-1:0]     best_record_q, best_record_d;

  logic [CNT_BITS-1:0] seeds_inc;
  assign seeds_inc = seeds_done_q + CNT_BITS'(1);

  always_comb begin
    state_d        = state_q;
    cur_seed_d     = cur_seed_q;
    count_d        = count_q;
    step_cnt_d     = step_cnt_q;
    seed_to_d      = seed_to_q;
    aborted_d      = aborted_q;
    timeout_seen_d = timeout_seen_q;
    wrapped_d      = wrapped_q;
    seeds_done_d   = seeds_done_q;
    best_seed_d    = best_seed_q;
    best_len_d     = best_len_q;
    best_record_d  = best_record_q;

    unique case (state_q)
      S_IDLE: begin
        // Start takes priority over a simultaneous abort; abort is ignored here.
        if (cmd_start) begin
          cur_seed_d     = cmd_base;
          count_d        = cmd_count;
          aborted_d      = 1'b0;
          timeout_seen_d = 1'b0;
          wrapped_d      = 1'b0;
          seeds_done_d   = '0;
          best_seed_d    = '0;
          best_len_d     = '0;
          best_record_d  = '0;
          state_d        = (cmd_count == '0) ? S_DONE : S_LOAD;
        end
      end

      S_LOAD: begin
        if (cmd_abort) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          step_cnt_d = '0;
          seed_to_d  = 1'b0;
          state_d    = S_RUN;
        end
      end

      S_RUN: begin
        if (cmd_abort) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          step_cnt_d = step_cnt_q + STEP_W'(1);
          if (!dp_busy) begin
            state_d = S_COLLECT;
          end else if (step_cnt_q == STEP_LAST) begin
            timeout_seen_d = 1'b1;
            seed_to_d      = 1'b1;
            state_d        = S_COLLECT;
          end
        end
      end

      S_COLLECT: begin
        // Abort beats collection: the seed in flight is dropped entirely.
        if (cmd_abort) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          // Strict compares keep the earlier seed on ties.
          if (!seed_to_q) begin
            if (dp_orbit_len > best_len_q) begin
              best_len_d  = dp_orbit_len;
              best_seed_d = cur_seed_q;
            end
            if (dp_path_record > best_record_q) begin
              best_record_d = dp_path_record;
            end
          end
          seeds_done_d = seeds_inc;
          if (seeds_inc == count_q) begin
            state_d = S_DONE;
          end else begin
            cur_seed_d = cur_seed_q + BITS'(1);
            if (cur_seed_q == '1) begin
              wrapped_d = 1'b1;
            end
            state_d = S_LOAD;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cur_seed_q     <= '0;
      count_q        <= '0;
      step_cnt_q     <= '0;
      seed_to_q      <= 1'b0;
      aborted_q      <= 1'b0;
      timeout_seen_q <= 1'b0;
      wrapped_q      <= 1'b0;
      seeds_done_q   <= '0;
      best_seed_q    <= '0;
      best_len_q     <= '0;
      best_record_q  <= '0;
    end else begin
      state_q        <= state_d;
      cur_seed_q     <= cur_seed_d;
      count_q        <= count_d;
      step_cnt_q     <= step_cnt_d;
      seed_to_q      <= seed_to_d;
      aborted_q      <= aborted_d;
      timeout_seen_q <= timeout_seen_d;
      wrapped_q      <= wrapped_d;
      seeds_done_q   <= seeds_done_d;
      best_seed_q    <= best_seed_d;
      best_len_q     <= best_len_d;
      best_record_q  <= best_record_d;
    end
  end

  // Control outputs are decodes of the state register; dp_run alone follows
  // dp_busy combinationally so the datapath never steps past its final value.
  assign dp_load      = (state_q == S_LOAD);
  assign dp_seed      = cur_seed_q;
  assign dp_run       = (state_q == S_RUN) && dp_busy;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign aborted      = aborted_q;
  assign timeout_seen = timeout_seen_q;
  assign wrapped      = wrapped_q;
  assign seeds_done   = seeds_done_q;
  assign best_seed    = best_seed_q;
  assign best_len     = best_len_q;
  assign best_record  = best_record_q;

endmodule

// File: tb/tb_collatz_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_collatz_sweep_ctrl
//
// Two controller instances:
//   A: 32-bit seeds, MAX_STEPS=112. Seed 27 (111 steps) just fits in the
//      budget; seed 54 (112 steps) just misses it.
//   B: 8-bit seeds, MAX_STEPS=64. Used for seed-counter wrap and for the
//      never-terminating seed 0.
// Each instance drives its own behavioural step datapath. Expected sweep
// results come from a constant table and from a reference sweep computed
// with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_collatz_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A ----------------
  logic        a_reset, a_cmd_start, a_cmd_abort;
  logic [31:0] a_cmd_base;
  logic [15:0] a_cmd_count;
  logic        a_dp_load, a_dp_run, a_dp_busy;
  logic [31:0] a_dp_seed, a_dp_orbit_len, a_dp_path_record;
  logic        a_busy, a_done, a_aborted, a_timeout_seen, a_wrapped;
  logic [15:0] a_seeds_done;
  logic [31:0] a_best_seed, a_best_len, a_best_record;

  collatz_sweep_ctrl #(.BITS(32), .CNT_BITS(16), .MAX_STEPS(112)) u_dut_a (
    .clk(clk), .reset(a_reset), .cmd_start(a_cmd_start), .cmd_base(a_cmd_base),
    .cmd_count(a_cmd_count), .cmd_abort(a_cmd_abort), .dp_load(a_dp_load),
    .dp_seed(a_dp_seed), .dp_run(a_dp_run), .dp_busy(a_dp_busy),
    .dp_orbit_len(a_dp_orbit_len), .dp_path_record(a_dp_path_record),
    .busy(a_busy), .done(a_done), .aborted(a_aborted),
    .timeout_seen(a_timeout_seen), .wrapped(a_wrapped),
    .seeds_done(a_seeds_done), .best_seed(a_best_seed),
    .best_len(a_best_len), .best_record(a_best_record)
  );

  // Step datapath model: busy until the value reaches 1.
  logic [31:0] a_val, a_len, a_rec, a_nxt;
  assign a_nxt = a_val[0] ? (a_val * 32'd3 + 32'd1) : (a_val >> 1);
  always @(posedge clk) begin
    if (a_dp_load) begin
      a_val <= a_dp_seed; a_len <= 32'd0; a_rec <= a_dp_seed;
    end else if (a_dp_run) begin
      a_val <= a_nxt; a_len <= a_len + 32'd1;
      if (a_nxt > a_rec) a_rec <= a_nxt;
    end
  end
  assign a_dp_busy        = (a_val != 32'd1);
  assign a_dp_orbit_len   = a_len;
  assign a_dp_path_record = a_rec;

  // ---------------- instance B ----------------
  logic        b_reset, b_cmd_start, b_cmd_abort;
  logic [7:0]  b_cmd_base;
  logic [15:0] b_cmd_count;
  logic        b_dp_load, b_dp_run, b_dp_busy;
  logic [7:0]  b_dp_seed, b_dp_orbit_len, b_dp_path_record;
  logic        b_busy, b_done, b_aborted, b_timeout_seen, b_wrapped;
  logic [15:0] b_seeds_done;
  logic [7:0]  b_best_seed, b_best_len, b_best_record;

  collatz_sweep_ctrl #(.BITS(8), .CNT_BITS(16), .MAX_STEPS(64)) u_dut_b (
    .clk(clk), .reset(b_reset), .cmd_start(b_cmd_start), .cmd_base(b_cmd_base),
    .cmd_count(b_cmd_count), .cmd_abort(b_cmd_abort), .dp_load(b_dp_load),
    .dp_seed(b_dp_seed), .dp_run(b_dp_run), .dp_busy(b_dp_busy),
    .dp_orbit_len(b_dp_orbit_len), .dp_path_record(b_dp_path_record),
    .busy(b_busy), .done(b_done), .aborted(b_aborted),
    .timeout_seen(b_timeout_seen), .wrapped(b_wrapped),
    .seeds_done(b_seeds_done), .best_seed(b_best_seed),
    .best_len(b_best_len), .best_record(b_best_record)
  );

  logic [7:0] b_val, b_len, b_rec, b_nxt;
  assign b_nxt = b_val[0] ? (b_val * 8'd3 + 8'd1) : (b_val >> 1);
  always @(posedge clk) begin
    if (b_dp_load) begin
      b_val <= b_dp_seed; b_len <= 8'd0; b_rec <= b_dp_seed;
    end else if (b_dp_run) begin
      b_val <= b_nxt; b_len <= b_len + 8'd1;
      if (b_nxt > b_rec) b_rec <= b_nxt;
    end
  end
  assign b_dp_busy        = (b_val != 8'd1);
  assign b_dp_orbit_len   = b_len;
  assign b_dp_path_record = b_rec;

  // ---------------- selected-instance view ----------------
  int sel;  // 0 = A, 1 = B
  logic        x_done, x_busy, x_aborted, x_to, x_wr, x_dp_load, x_dp_run;
  logic [63:0] x_seeds_done, x_best_seed, x_best_len, x_best_rec, x_dp_seed;
  always_comb begin
    if (sel == 0) begin
      x_done = a_done; x_busy = a_busy; x_aborted = a_aborted;
      x_to = a_timeout_seen; x_wr = a_wrapped; x_dp_load = a_dp_load;
      x_dp_run = a_dp_run; x_seeds_done = 64'(a_seeds_done);
      x_best_seed = 64'(a_best_seed); x_best_len = 64'(a_best_len);
      x_best_rec = 64'(a_best_record); x_dp_seed = 64'(a_dp_seed);
    end else begin
      x_done = b_done; x_busy = b_busy; x_aborted = b_aborted;
      x_to = b_timeout_seen; x_wr = b_wrapped; x_dp_load = b_dp_load;
      x_dp_run = b_dp_run; x_seeds_done = 64'(b_seeds_done);
      x_best_seed = 64'(b_best_seed); x_best_len = 64'(b_best_len);
      x_best_rec = 64'(b_best_record); x_dp_seed = 64'(b_dp_seed);
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    longint base;
    longint count;
    longint seeds_done;
    longint best_seed;
    longint best_len;
    longint best_rec;
    bit     to;
    bit     wr;
  } vec_t;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // One seed: a seed times out when it needs max_steps or more steps.
  task automatic ref_seed(input longint seed, input longint mask, input int max_steps,
                          output bit to, output longint len, output longint rec);
    longint v;
    v = seed; len = 0; rec = seed;
    while (v != 1 && len < max_steps) begin
      if (v % 2 == 0) v = v / 2;
      else v = (3 * v + 1) & mask;
      len++;
      if (v > rec) rec = v;
    end
    to = (len >= max_steps);
  endtask

  task automatic ref_sweep(input longint base, input longint count, input longint mask,
                           input int max_steps, output vec_t r);
    bit to; longint len, rec, seed;
    r.base = base; r.count = count; r.seeds_done = count;
    r.best_seed = 0; r.best_len = 0; r.best_rec = 0; r.to = 0;
    r.wr = (count != 0) && (base + count - 1 > mask);
    for (longint i = 0; i < count; i++) begin
      seed = (base + i) & mask;
      ref_seed(seed, mask, max_steps, to, len, rec);
      if (to) r.to = 1;
      else begin
        if (len > r.best_len) begin r.best_len = len; r.best_seed = seed; end
        if (rec > r.best_rec) r.best_rec = rec;
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_start(input longint base, input longint count, input bit with_abort);
    if (sel == 0) begin
      a_cmd_base = base[31:0]; a_cmd_count = count[15:0];
      a_cmd_start = 1'b1; a_cmd_abort = with_abort;
    end else begin
      b_cmd_base = base[7:0]; b_cmd_count = count[15:0];
      b_cmd_start = 1'b1; b_cmd_abort = with_abort;
    end
    tick();
    a_cmd_start = 1'b0; a_cmd_abort = 1'b0;
    b_cmd_start = 1'b0; b_cmd_abort = 1'b0;
  endtask

  // cyc = cycles from the first cycle after the accepted start to done.
  task automatic wait_done(input int budget, output int cyc, output int runs, output bit seen);
    seen = 0; cyc = 0; runs = 0;
    for (int c = 0; c <= budget; c++) begin
      if (x_done) begin seen = 1; cyc = c; break; end
      if (x_dp_run) runs++;
      tick();
    end
  endtask

  task automatic check_results(input string tag, input vec_t e);
    check({tag, ".seeds_done"}, x_seeds_done, 64'(e.seeds_done));
    check({tag, ".best_seed"},  x_best_seed,  64'(e.best_seed));
    check({tag, ".best_len"},   x_best_len,   64'(e.best_len));
    check({tag, ".best_rec"},   x_best_rec,   64'(e.best_rec));
    check({tag, ".timeout"},    64'(x_to),    64'(e.to));
    check({tag, ".wrapped"},    64'(x_wr),    64'(e.wr));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".busy"},       64'(x_busy),    64'd0);
    check({tag, ".done"},       64'(x_done),    64'd0);
    check({tag, ".aborted"},    64'(x_aborted), 64'd0);
    check({tag, ".timeout"},    64'(x_to),      64'd0);
    check({tag, ".wrapped"},    64'(x_wr),      64'd0);
    check({tag, ".dp_load"},    64'(x_dp_load), 64'd0);
    check({tag, ".dp_run"},     64'(x_dp_run),  64'd0);
    check({tag, ".dp_seed"},    x_dp_seed,      64'd0);
    check({tag, ".seeds_done"}, x_seeds_done,   64'd0);
    check({tag, ".best_seed"},  x_best_seed,    64'd0);
    check({tag, ".best_len"},   x_best_len,     64'd0);
    check({tag, ".best_rec"},   x_best_rec,     64'd0);
  endtask

  task automatic sweep_check(input string tag, input vec_t e, input int max_steps);
    int cyc, runs; bit seen;
    drive_start(e.base, e.count, 1'b0);
    wait_done(int'(e.count) * (max_steps + 2) + 10, cyc, runs, seen);
    check({tag, ".done_seen"}, 64'(seen), 64'd1);
    check_results(tag, e);
    check({tag, ".aborted"}, 64'(x_aborted), 64'd0);
    tick();
    check({tag, ".done_single"}, 64'(x_done), 64'd0);
    check({tag, ".idle"}, 64'(x_busy), 64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  vec_t tbl[6];
  vec_t e;
  int   cyc, runs;
  bit   seen, found;
  int   npulse;

  initial begin
    tbl[0] = '{1, 10, 10, 9, 19, 52, 0, 0};
    tbl[1] = '{27, 1, 1, 27, 111, 9232, 0, 0};
    tbl[2] = '{54, 1, 1, 0, 0, 0, 1, 0};       // 112 steps: one past the budget
    tbl[3] = '{1, 1, 1, 0, 0, 1, 0, 0};        // orbit 0 never beats best_len 0
    tbl[4] = '{26, 3, 3, 27, 111, 9232, 0, 0};
    tbl[5] = '{53, 2, 2, 53, 11, 160, 1, 0};

    sel = 0;
    a_reset = 1'b1; a_cmd_start = 1'b0; a_cmd_abort = 1'b0;
    a_cmd_base = '0; a_cmd_count = '0;
    b_reset = 1'b1; b_cmd_start = 1'b0; b_cmd_abort = 1'b0;
    b_cmd_base = '0; b_cmd_count = '0;
    repeat (3) tick();
    a_reset = 1'b0; b_reset = 1'b0;
    tick();

    sel = 0; check_zero("reset_a");
    sel = 1; check_zero("reset_b");

    // Table-driven sweeps on A.
    sel = 0;
    for (int i = 0; i < 6; i++) sweep_check($sformatf("tbl%0d", i), tbl[i], 112);

    // Seed 27 timing: done 114 cycles after the LOAD cycle.
    drive_start(27, 1, 1'b0);
    check("t27.dp_load", 64'(x_dp_load), 64'd1);
    check("t27.dp_seed", x_dp_seed, 64'd27);
    wait_done(200, cyc, runs, seen);
    check("t27.done_seen", 64'(seen), 64'd1);
    check("t27.latency", 64'(cyc), 64'd114);
    check("t27.runs", 64'(runs), 64'd111);
    tick();

    // count == 0: done in the cycle right after the start is taken, results cleared.
    drive_start(0, 0, 1'b0);
    check("cnt0.done", 64'(x_done), 64'd1);
    check("cnt0.seeds_done", x_seeds_done, 64'd0);
    check("cnt0.best_len", x_best_len, 64'd0);
    check("cnt0.best_rec", x_best_rec, 64'd0);
    check("cnt0.best_seed", x_best_seed, 64'd0);
    tick();
    check("cnt0.done_single", 64'(x_done), 64'd0);

    // Abort in the middle of seed 3's RUN phase.
    drive_start(1, 10, 1'b0);
    found = 0;
    for (int c = 0; c < 200; c++) begin
      if (x_dp_load && x_dp_seed == 64'd3) begin found = 1; break; end
      tick();
    end
    check("abort.seed3_load", 64'(found), 64'd1);
    tick(); tick();
    a_cmd_abort = 1'b1; tick(); a_cmd_abort = 1'b0;
    check("abort.done", 64'(x_done), 64'd1);
    check("abort.aborted", 64'(x_aborted), 64'd1);
    check("abort.seeds_done", x_seeds_done, 64'd2);
    check("abort.best_seed", x_best_seed, 64'd2);
    check("abort.best_len", x_best_len, 64'd1);
    check("abort.best_rec", x_best_rec, 64'd2);
    tick();
    check("abort.done_single", 64'(x_done), 64'd0);
    check("abort.idle", 64'(x_busy), 64'd0);
    a_cmd_abort = 1'b1; tick(); a_cmd_abort = 1'b0;
    check("abort_idle.busy", 64'(x_busy), 64'd0);
    check("abort_idle.done", 64'(x_done), 64'd0);
    check("abort_idle.aborted_held", 64'(x_aborted), 64'd1);

    // Start and abort together in IDLE: start wins and clears aborted.
    drive_start(5, 1, 1'b1);
    check("start_abort.busy", 64'(x_busy), 64'd1);
    wait_done(200, cyc, runs, seen);
    check("start_abort.done_seen", 64'(seen), 64'd1);
    check("start_abort.aborted", 64'(x_aborted), 64'd0);
    check("start_abort.best_len", x_best_len, 64'd5);
    check("start_abort.best_rec", x_best_rec, 64'd16);
    tick();

    // A second start pulsed mid-sweep is ignored.
    drive_start(1, 10, 1'b0);
    repeat (5) tick();
    a_cmd_base = 32'd100; a_cmd_count = 16'd1; a_cmd_start = 1'b1;
    tick(); a_cmd_start = 1'b0;
    wait_done(2000, cyc, runs, seen);
    check("busy_start.done_seen", 64'(seen), 64'd1);
    check_results("busy_start", tbl[0]);
    tick();

    // Randomized sweeps on A.
    for (int i = 0; i < 8; i++) begin
      ref_sweep(longint'($urandom_range(300, 1)), longint'($urandom_range(6, 1)),
                64'hFFFF_FFFF, 112, e);
      sweep_check($sformatf("rnd_a%0d", i), e, 112);
    end

    // Reset in the middle of RUN: everything clears, no done follows.
    drive_start(27, 1, 1'b0);
    repeat (10) tick();
    check("rst_mid.busy_before", 64'(x_busy), 64'd1);
    a_reset = 1'b1; tick();
    check_zero("rst_mid");
    a_reset = 1'b0;
    npulse = 0;
    for (int c = 0; c < 150; c++) begin
      if (x_done) npulse++;
      tick();
    end
    check("rst_mid.no_done", 64'(npulse), 64'd0);

    // Instance B: seed 0 never reaches 1 and uses the whole budget.
    sel = 1;
    drive_start(0, 1, 1'b0);
    check("seed0.dp_load", 64'(x_dp_load), 64'd1);
    wait_done(200, cyc, runs, seen);
    check("seed0.done_seen", 64'(seen), 64'd1);
    check("seed0.run_cycles", 64'(runs), 64'd64);
    check("seed0.latency", 64'(cyc), 64'd66);
    check("seed0.timeout", 64'(x_to), 64'd1);
    check("seed0.best_len", x_best_len, 64'd0);
    check("seed0.best_rec", x_best_rec, 64'd0);
    check("seed0.seeds_done", x_seeds_done, 64'd1);
    tick();

    // Instance B: seed counter wraps from 255 to 0.
    ref_sweep(255, 2, 64'hFF, 64, e);
    drive_start(255, 2, 1'b0);
    found = 0;
    for (int c = 0; c < 100; c++) begin
      if (x_dp_load && x_dp_seed == 64'd0) begin found = 1; break; end
      tick();
    end
    check("wrap.seed0_load", 64'(found), 64'd1);
    check("wrap.wrapped_at_load", 64'(x_wr), 64'd1);
    wait_done(200, cyc, runs, seen);
    check("wrap.done_seen", 64'(seen), 64'd1);
    check("wrap.timeout", 64'(x_to), 64'd1);
    check("wrap.seeds_done", x_seeds_done, 64'd2);
    check_results("wrap", e);
    tick();

    // Randomized sweeps on B (wrap and timeouts both reachable).
    for (int i = 0; i < 6; i++) begin
      ref_sweep(longint'($urandom_range(255, 0)), longint'($urandom_range(4, 1)),
                64'hFF, 64, e);
      sweep_check($sformatf("rnd_b%0d", i), e, 64);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
